readout_controller: RTL and testbench

Sequencer and stream interface for the pixel readout shifter. On a `start` request it clears the shifter, parallel-loads it with a held `set_select` window, then emits the `length` words one at a time on a valid/ready stream, pulsing `shift` between words. It sits directly downstream of the row register bank and drives the shifter's control pins. It also consumes the shifter's `data_out`, converting the shifter's edge-driven interface into a clocked, back-pressurable word stream for the output link.

---
 rtl/readout_pkg.sv | 19 +
 rtl/readout_controller.sv | 86 ++++++++
 tb/tb_readout_controller.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/readout_pkg.sv
// Shared definitions for the pixel readout controller and its shifter instance.
package readout_pkg;

  localparam int BITS_DEF   = 4;
  localparam int LENGTH_DEF = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_SEL_SETUP,
    S_SEL_PULSE,
    S_SEL_HOLD,
    S_CAPTURE,
    S_PRESENT,
    S_SHIFT_PULSE,
    S_SHIFT_SETTLE
  } readout_state_t;

endpackage

// File: rtl/readout_controller.sv
// Sequences the pixel readout shifter (clear, windowed load, shift) and turns
// its data_out into a registered valid/ready word stream.
module readout_controller
  import readout_pkg::*;
#(
  parameter int bits   = BITS_DEF,
  parameter int length = LENGTH_DEF,
  parameter int IDX_W  = $clog2(length)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             sh_reset,
  output logic             sh_set,
  output logic             sh_set_select,
  output logic             sh_shift,
  input  logic [bits-1:0]  sh_data,
  output logic [bits-1:0]  out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(length - 1);

  readout_state_t state, nxt;
  logic accept, at_last;

  assign accept   = (state == S_PRESENT) && out_valid && out_ready;
  assign at_last  = (out_index == LAST);
  assign busy     = (state != S_IDLE);
  assign out_last = out_valid && at_last;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:         if (start) nxt = S_CLEAR;
      S_CLEAR:        nxt = S_SEL_SETUP;
      S_SEL_SETUP:    nxt = S_SEL_PULSE;
      S_SEL_PULSE:    nxt = S_SEL_HOLD;
      S_SEL_HOLD:     nxt = S_CAPTURE;
      S_CAPTURE:      nxt = S_PRESENT;
      S_PRESENT:      if (accept) nxt = at_last ? S_IDLE : S_SHIFT_PULSE;
      S_SHIFT_PULSE:  nxt = S_SHIFT_SETTLE;
      S_SHIFT_SETTLE: nxt = S_CAPTURE;
      default:        nxt = S_IDLE;
    endcase
    // Abort beats everything, including an accept in the same cycle.
    if (abort && state != S_IDLE) nxt = S_IDLE;
  end

  // Shifter strobes are decoded from the next state and registered, so each
  // pin comes straight off a flop and lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      done          <= 1'b0;
      sh_reset      <= 1'b0;
      sh_set        <= 1'b0;
      sh_set_select <= 1'b0;
      sh_shift      <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_index     <= '0;
    end else begin
      state         <= nxt;
      sh_reset      <= (nxt == S_CLEAR);
      sh_set_select <= (nxt inside {S_SEL_SETUP, S_SEL_PULSE, S_SEL_HOLD});
      sh_set        <= (nxt == S_SEL_PULSE);
      sh_shift      <= (nxt == S_SHIFT_PULSE);
      out_valid     <= (nxt == S_PRESENT);
      done          <= accept && at_last && !abort;
      if (state == S_CLEAR)
        out_index <= '0;
      else if (accept && !at_last && !abort)
        out_index <= out_index + 1'b1;
      if (state == S_CAPTURE)
        out_data <= sh_data;
    end
  end

endmodule

// File: tb/tb_readout_controller.sv
// Directed bench for readout_controller with a behavioural shifter loaded 3,5,9,12.
module tb_readout_controller;
  import readout_pkg::*;

  localparam int BITS = BITS_DEF;
  localparam int LEN  = LENGTH_DEF;
  localparam int IW   = $clog2(LEN);

  logic            clk = 1'b0;
  logic            reset = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic            busy, done, sh_reset, sh_set, sh_set_select, sh_shift;
  logic            out_last, out_valid;
  logic [BITS-1:0] sh_data, out_data;
  logic [IW-1:0]   out_index;

  always #5 clk = ~clk;

  readout_controller #(.bits(BITS), .length(LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .sh_reset(sh_reset), .sh_set(sh_set), .sh_set_select(sh_set_select),
    .sh_shift(sh_shift), .sh_data(sh_data),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // Shifter model: word 0 on data_out, shift moves the next word down.
  logic [BITS-1:0] shreg [LEN] = '{default: '0};
  logic [BITS-1:0] load_vals [LEN] = '{4'd3, 4'd5, 4'd9, 4'd12};
  always @(posedge clk) begin
    if (sh_reset) begin
      for (int i = 0; i < LEN; i++) shreg[i] <= '0;
    end else if (sh_set && sh_set_select) begin
      for (int i = 0; i < LEN; i++) shreg[i] <= load_vals[i];
    end else if (sh_shift) begin
      for (int i = 0; i < LEN - 1; i++) shreg[i] <= shreg[i+1];
      shreg[LEN-1] <= '0;
    end
  end
  assign sh_data = shreg[0];

  int n_chk = 0, n_fail = 0;
  int cyc, nw, nv, shift_cnt, done_cnt, done_cyc, overlap, unstable;
  logic busy_at_done;
  logic [31:0] selm, setm, rstm, shm;
  int w_data [8], w_idx [8], w_last [8], vstart [8];
  logic p_valid = 1'b0, p_last = 1'b0;
  logic [BITS-1:0] p_data = '0;
  logic [IW-1:0] p_idx = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_mon();
    cyc = 0; nw = 0; nv = 0; shift_cnt = 0; done_cnt = 0; done_cyc = -1;
    overlap = 0; unstable = 0; busy_at_done = 1'b1;
    selm = '0; setm = '0; rstm = '0; shm = '0;
  endtask

  // One clock: sample at the falling edge, before the driver touches inputs.
  // Inputs still hold what the DUT sampled on the preceding rising edge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (p_valid && reset && !abort) begin
      if (out_ready) begin
        if (nw < 8) begin
          w_data[nw] = int'(p_data); w_idx[nw] = int'(p_idx); w_last[nw] = int'(p_last);
        end
        nw++;
      end else if (out_data !== p_data || out_index !== p_idx || out_last !== p_last || out_valid !== 1'b1)
        unstable++;
    end
    if (out_valid === 1'b1 && !p_valid) begin
      if (nv < 8) vstart[nv] = cyc;
      nv++;
    end
    if (int'(sh_reset === 1'b1) + int'(sh_set === 1'b1) + int'(sh_shift === 1'b1) > 1) overlap++;
    if (cyc < 32) begin
      selm |= 32'(sh_set_select === 1'b1) << cyc;
      setm |= 32'(sh_set === 1'b1) << cyc;
      rstm |= 32'(sh_reset === 1'b1) << cyc;
      shm  |= 32'(sh_shift === 1'b1) << cyc;
    end
    if (sh_shift === 1'b1) shift_cnt++;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
    p_valid = (out_valid === 1'b1); p_data = out_data; p_idx = out_index; p_last = out_last;
  endtask

  // Start is sampled on the next rising edge ("edge 0"); cycle 1 follows.
  task automatic go();
    start = 1'b1;
    clear_mon();
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max && done_cnt == 0; i++) cycle();
  endtask

  initial begin
    clear_mon();
    reset = 1'b0;
    repeat (3) cycle();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sh", {sh_reset, sh_set, sh_set_select, sh_shift}, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    reset = 1'b1;
    cycle();

    // Nominal readout, ready held high
    out_ready = 1'b1;
    go();
    wait_done(40);
    chk("t1_nwords", nw, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_data%0d", i), w_data[i], int'(load_vals[i]));
      chk($sformatf("t1_idx%0d", i), w_idx[i], i);
      chk($sformatf("t1_last%0d", i), w_last[i], (i == 3) ? 1 : 0);
      chk($sformatf("t1_vstart%0d", i), vstart[i], 6 + 4 * i);
    end
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_cyc", done_cyc, 19);
    chk("t1_busy_at_done", busy_at_done, 0);
    chk("t1_rst_mask", rstm, 32'h2);
    chk("t1_sel_mask", selm, 32'h1c);
    chk("t1_set_mask", setm, 32'h8);
    chk("t1_shift_mask", shm, 32'h8880);
    chk("t1_overlap", overlap, 0);

    // Back-to-back start in the done cycle; word 1 stalled for 7 cycles,
    // and a start mid-readout must be ignored.
    go();
    chk("t2_b2b_busy", busy, 1);
    begin
      int hold = 0;
      for (int i = 0; i < 60 && done_cnt == 0; i++) begin
        cycle();
        start = (cyc == 12);
        out_ready = !(out_valid && out_index == 1 && hold < 7);
        if (!out_ready) hold++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("t2_nwords", nw, 4);
    chk("t2_data1", w_data[1], 5);
    chk("t2_unstable", unstable, 0);
    chk("t2_shifts", shift_cnt, 3);
    chk("t2_vstart2", vstart[2], 21);
    chk("t2_done_cyc", done_cyc, 26);
    repeat (3) cycle();
    chk("t2_idle_after", busy, 0);

    // Abort during SHIFT_SETTLE after word 1
    go();
    while (cyc < 12) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("t3_busy", busy, 0);
    chk("t3_valid", out_valid, 0);
    chk("t3_sh", {sh_reset, sh_set, sh_set_select, sh_shift}, 0);
    repeat (4) cycle();
    chk("t3_no_done", done_cnt, 0);
    chk("t3_nwords", nw, 2);
    go();
    wait_done(40);
    chk("t3_re_nwords", nw, 4);
    chk("t3_re_data0", w_data[0], 3);
    chk("t3_re_idx0", w_idx[0], 0);

    // start with abort in IDLE starts; abort with accept loses the word
    abort = 1'b1;
    go();
    abort = 1'b0;
    chk("t4_busy", busy, 1);
    chk("t4_sh_reset", sh_reset, 1);
    while (cyc < 10) cycle();
    chk("t4_pre_idx", out_index, 1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_done", done, 0);
    chk("t4_abort_idx", out_index, 1);
    chk("t4_abort_nwords", nw, 1);
    chk("t4_abort_shifts", shift_cnt, 1);

    // Reset during PRESENT of word 2
    cycle();
    go();
    while (cyc < 14) cycle();
    chk("t5_pre_data", out_data, 9);
    reset = 1'b0;
    cycle();
    chk("t5_rst_all", {busy, done, sh_reset, sh_set, sh_set_select, sh_shift,
                       out_valid, out_last, out_index, out_data}, 0);
    reset = 1'b1;
    cycle();
    go();
    wait_done(40);
    chk("t5_nwords", nw, 4);
    chk("t5_data3", w_data[3], 12);
    chk("t5_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
